// File: rtl/pattern_scan_ctrl.sv
// Byte-stream scan controller: serializes accepted bytes MSB-first into a PAT_W-bit history
// and counts overlapping pattern matches over a win_len-byte window. Optional macro: SCAN_ABORT_EN.
module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SCAN_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIN_W-1:0] win_len,
    input  logic [PAT_W-1:0] pattern,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             detect,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam int SEEN_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready are both high;
    // in_ready depends only on the current state, never on in_valid.

    state_t              state_q, state_d;
    logic [PAT_W-1:0]    pat_q;
    logic [WIN_W-1:0]    bytes_left_q;
    logic [7:0]          byte_q;
    logic [2:0]          bit_idx_q;
    logic [PAT_W-1:0]    hist_q;
    logic [SEEN_W-1:0]   seen_q;
    logic [CNT_W-1:0]    count_q;
    logic                detect_q, detect_d;
    logic                done_q, done_d;

    logic                abort_w;
    logic [PAT_W-1:0]    hist_next;
    logic                seen_full;
    logic                hit;
    logic                last_bit;
    logic                last_byte;

`ifdef SCAN_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign hist_next = {hist_q[PAT_W-2:0], byte_q[bit_idx_q]};
    assign seen_full = (seen_q >= SEEN_W'(PAT_W - 1));
    assign hit       = (state_q == S_SHIFT) && seen_full && (hist_next == pat_q);
    assign last_bit  = (bit_idx_q == 3'd0);
    assign last_byte = (bytes_left_q == WIN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            detect_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            detect_q <= detect_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (win_len == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_w) begin
                    state_d = S_DONE;
                end else if (in_valid) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort_w) begin
                    state_d = S_DONE;
                end else if (last_bit) begin
                    state_d = last_byte ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_WAIT);
        busy     = (state_q != S_IDLE);
        detect_d = hit;
        done_d   = (state_d == S_DONE);
    end

    // A match on an aborting SHIFT cycle still counts: the shift and count run regardless of abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q        <= '0;
            bytes_left_q <= '0;
            byte_q       <= '0;
            bit_idx_q    <= '0;
            hist_q       <= '0;
            seen_q       <= '0;
            count_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pat_q        <= pattern;
                        bytes_left_q <= win_len;
                        hist_q       <= '0;
                        seen_q       <= '0;
                        count_q      <= '0;
                    end
                end
                S_WAIT: begin
                    if (in_valid && !abort_w) begin
                        byte_q    <= in_data;
                        bit_idx_q <= 3'd7;
                    end
                end
                S_SHIFT: begin
                    hist_q    <= hist_next;
                    seen_q    <= seen_full ? SEEN_W'(PAT_W) : seen_q + SEEN_W'(1);
                    bit_idx_q <= bit_idx_q - 3'd1;
                    if (hit && (count_q != '1)) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    if (last_bit) begin
                        bytes_left_q <= bytes_left_q - WIN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign detect      = detect_q;
    assign done        = done_q;
    assign match_count = count_q;

endmodule
